// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, block/column widths, GF(2^8) helpers.
// Imported by mix_column_seq and gf_mix_col.
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_COL_W = 32;

    localparam logic [7:0] GF_POLY = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

    // Multiply by a constant k < 16 as a sum of b, 2b, 4b, 8b.
    function automatic logic [7:0] gf_mul(input logic [7:0] b,
                                          input logic [3:0] k);
        logic [7:0] x1;
        logic [7:0] x2;
        logic [7:0] x3;
        x1 = xtime(b);
        x2 = xtime(x1);
        x3 = xtime(x2);
        return ({8{k[0]}} & b)  ^ ({8{k[1]}} & x1) ^
               ({8{k[2]}} & x2) ^ ({8{k[3]}} & x3);
    endfunction

endpackage

// File: rtl/mix_column_seq_if.sv
// Handshake bundle of mix_column_seq: input block channel and result channel.
// slave = the mixer, master = the producer/consumer driving it.
interface mix_column_seq_if;
    import aes_pkg::*;

    logic                 i_Valid;
    logic                 o_Ready;
    logic [AES_BLK_W-1:0] i_Data;
    logic                 i_fDec;
    logic                 o_Valid;
    logic                 i_Ready;
    logic [AES_BLK_W-1:0] o_Data;

    modport slave (
        input  i_Valid, i_Data, i_fDec, i_Ready,
        output o_Ready, o_Valid, o_Data
    );

    modport master (
        output i_Valid, i_Data, i_fDec, i_Ready,
        input  o_Ready, o_Valid, o_Data
    );

endinterface

// File: rtl/gf_mix_col.sv
// Combinational (Inv)MixColumns of one 32-bit column; row 0 byte in MSB.
// Ports: col_i, fdec_i (1 = inverse) -> col_o. fdec_i only used with MIX_COLUMN_DEC_EN.
module gf_mix_col
    import aes_pkg::*;
(
    input  logic [AES_COL_W-1:0] col_i,
    input  logic                 fdec_i,
    output logic [AES_COL_W-1:0] col_o
);

    logic [7:0] a0, a1, a2, a3;
    logic [3:0] k0, k1, k2, k3;

    assign {a0, a1, a2, a3} = col_i;

`ifdef MIX_COLUMN_DEC_EN
    assign {k0, k1, k2, k3} = fdec_i ? 16'hEBD9 : 16'h2311;
`else
    logic unused_fdec;
    assign unused_fdec = fdec_i;
    assign {k0, k1, k2, k3} = 16'h2311;
`endif

    // Circulant matrix: row i uses coefficient kn on byte a(i+n mod 4).
    assign col_o = {
        gf_mul(a0, k0) ^ gf_mul(a1, k1) ^ gf_mul(a2, k2) ^ gf_mul(a3, k3),
        gf_mul(a1, k0) ^ gf_mul(a2, k1) ^ gf_mul(a3, k2) ^ gf_mul(a0, k3),
        gf_mul(a2, k0) ^ gf_mul(a3, k1) ^ gf_mul(a0, k2) ^ gf_mul(a1, k3),
        gf_mul(a3, k0) ^ gf_mul(a0, k1) ^ gf_mul(a1, k2) ^ gf_mul(a2, k3)
    };

endmodule

// File: rtl/mix_column_seq.sv
// Sequential AES MixColumns: one column per clock through a shared gf_mix_col.
// Ports: i_Clk, i_Rst (sync, active high), bus (slave handshake bundle).
// Optional macro MIX_COLUMN_DEC_EN enables InvMixColumns via i_fDec.
module mix_column_seq
    import aes_pkg::*;
(
    input  logic              i_Clk,
    input  logic              i_Rst,
    mix_column_seq_if.slave   bus
);

    state_t               state_q;
    logic [1:0]           cnt_q;
    logic [AES_BLK_W-1:0] data_q;
    logic                 fdec_q;
    logic                 ovalid_q;
    logic                 ordy_q;
    logic [AES_BLK_W-1:0] odata_q;

    logic [1:0]           col_sel;
    logic [AES_COL_W-1:0] col_in;
    logic [AES_COL_W-1:0] col_d;

    // Column j lives at bits [(3-j)*32 +: 32], and 3-j == ~j for 2 bits.
    assign col_sel = ~cnt_q;
    assign col_in  = data_q[{col_sel, 5'd0} +: AES_COL_W];

    gf_mix_col u_col (
        .col_i  (col_in),
        .fdec_i (fdec_q),
        .col_o  (col_d)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 2'd0;
            data_q   <= '0;
            fdec_q   <= 1'b0;
            ovalid_q <= 1'b0;
            ordy_q   <= 1'b1;
            odata_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.i_Valid) begin
                        state_q <= ST_BUSY;
                        data_q  <= bus.i_Data;
                        fdec_q  <= bus.i_fDec;
                        cnt_q   <= 2'd0;
                        ordy_q  <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    odata_q[{col_sel, 5'd0} +: AES_COL_W] <= col_d;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_q  <= ST_DONE;
                        ovalid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Returning to IDLE first keeps a pending result from
                    // ever overlapping a new accept.
                    if (bus.i_Ready) begin
                        state_q  <= ST_IDLE;
                        ovalid_q <= 1'b0;
                        ordy_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    ovalid_q <= 1'b0;
                    ordy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_Ready = ordy_q;
    assign bus.o_Valid = ovalid_q;
    assign bus.o_Data  = odata_q;

endmodule

// File: doc/mix_column_seq.md
MIX_COLUMN_SEQ -- requirements
Module: mix_column_seq

Interface
REQ-001 SHALL have clock and reset: i_Clk input 1 (rising-edge clock); i_Rst input 1 (synchronous, active-high reset).
REQ-002 SHALL have input handshake: i_Valid input 1 (block offered); o_Ready output 1 (block can be accepted).
REQ-003 SHALL have i_Data input 128: ShiftRow result; column j at bits [(3-j)*32 +: 32], row 0 byte in the MSB of each column.
REQ-004 SHALL have i_fDec input 1: 0 = MixColumns, 1 = InvMixColumns; sampled on accept.
REQ-005 SHALL have output handshake: o_Valid output 1 (result available); i_Ready input 1 (consumer takes the result).
REQ-006 SHALL have o_Data output 128: mixed block, with the same column and row layout as i_Data.

Function
REQ-007 SHALL implement FSM states IDLE, BUSY, DONE.
- IDLE: o_Ready=1. On i_Valid, go to BUSY, latch i_Data and i_fDec, and clear column counter to 0.
REQ-008 SHALL, in BUSY, transform one column per clock (counter 0..3) into o_Data from the latched block.
- At counter=3, go to DONE and wrap the counter to 0.
REQ-009 SHALL, in DONE, hold o_Valid=1 and o_Data stable until i_Ready=1, then return to IDLE.
- o_Valid deasserts on the same edge.
REQ-010 SHALL keep o_Ready=0 in BUSY and DONE; i_Valid and i_Data SHALL be ignored outside IDLE.
- A block SHALL never be accepted while a result is pending.
REQ-011 Latency SHALL be fixed: o_Valid rises exactly 4 clocks after the accept edge.
- Minimum spacing between accepts SHALL be 6 clocks when i_Ready is held high.
REQ-012 SHALL use xtime(b) = {b[6:0],0} XOR (b[7] ? 8'h1B : 0); all products SHALL be 8-bit GF(2^8).
REQ-013 Encrypt column (a0..a3): r_i = 2*a_i ^ 3*a_(i+1) ^ a_(i+2) ^ a_(i+3), indices mod 4.
REQ-014 Decrypt column: r_i = 0E*a_i ^ 0B*a_(i+1) ^ 0D*a_(i+2) ^ 09*a_(i+3), indices mod 4.
REQ-015 i_fDec changes after accept SHALL NOT affect the block in flight.
REQ-016 Simultaneous i_Ready=1 in DONE and i_Valid=1 SHALL only complete the output; the new block SHALL be accepted next cycle (IDLE).

Reset
REQ-017 On i_Rst=1 at a clock edge, the block SHALL reset these registers: state IDLE, counter 0, o_Valid 0, o_Data 128'h0, latched data 0, latched fDec 0.
REQ-018 Reset SHALL take priority over all handshakes.
- Reset mid-BUSY or mid-DONE SHALL discard the block silently.
- o_Ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-019 Macro MIX_COLUMN_DEC_EN defined: i_fDec selects InvMixColumns per REQ-014.
REQ-020 Macro MIX_COLUMN_DEC_EN undefined:
- The port i_fDec SHALL remain and SHALL be ignored.
- Only the REQ-013 datapath SHALL be synthesized; latency and handshake SHALL be unchanged.

Structure
REQ-021 Shared package aes_pkg SHALL hold:
- FSM state encoding (IDLE/BUSY/DONE);
- AES_BLK_W=128 and AES_COL_W=32;
- GF reduction constant 8'h1B.
REQ-022 One combinational sub-module gf_mix_col SHALL transform a single 32-bit column (inputs column and fDec), instantiated once and time-shared across the 4 BUSY cycles.

Verification
REQ-023 Encrypt: columns db135345, f20a225c, 01010101, c6c6c6c6, i_fDec=0 -> o_Data = 8e4da1bc 9fdc589d 01010101 c6c6c6c6, with o_Valid 4 clocks after accept.
REQ-024 Decrypt (MIX_COLUMN_DEC_EN): columns 8e4da1bc, 9fdc589d, d5d5d7d6, 4d7ebdf8, i_fDec=1 -> o_Data = db135345 f20a225c d4d4d4d5 2d26314c.
REQ-025 Backpressure: hold i_Ready=0 for 10 clocks in DONE while driving i_Valid=1 with new data -> o_Data stable, o_Ready=0, and the second block accepted only after the i_Ready handshake.
REQ-026 Reset mid-op: assert i_Rst at BUSY counter=2 -> next cycle o_Valid=0, o_Data=0, o_Ready=1, and no result emitted.
REQ-027 fDec glitch: accept with i_fDec=0, toggle i_fDec to 1 during BUSY -> encrypt result per REQ-023.
REQ-028 Back-to-back: 3 blocks with i_Valid and i_Ready held high -> 3 correct outputs, accepts spaced 6 clocks apart.
